imem_loader: RTL and testbench

//  Boot-time program loader that sits directly upstream of the CPU top.
//  - Accepts a byte stream over a valid/ready handshake and packs it little-endian into 32-bit instructions.
//  - Writes each word through the instruction-memory external port (addr_ext/wen_ext/wdata_ext).
//  - Raises cpu_enable once the whole program is resident.

---
 rtl/loader_pkg.sv | 17 +
 rtl/loader_byte_packer.sv | 40 ++++
 rtl/imem_loader.sv | 132 +++++++++++++
 tb/tb_imem_loader.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// Optional feature macro: LOADER_CHECKSUM_EN (adds the CHECK state).
package loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_W         = 8;

    typedef enum logic [2:0] {
        StIdle,
        StRecv,
        StWrite,
        StCheck,
        StDone,
        StError
    } loader_state_t;

endpackage

// File: rtl/loader_byte_packer.sv
// Packs an accepted byte stream little-endian into 32-bit words.
// Used by imem_loader; behaviour does not depend on LOADER_CHECKSUM_EN.
module loader_byte_packer
    import loader_pkg::*;
(
    input  logic                             clk,
    input  logic                             arst,
    input  logic                             clear,
    input  logic                             accept,
    input  logic [BYTE_W-1:0]                data,
    output logic                             word_valid,
    output logic [BYTES_PER_WORD*BYTE_W-1:0] word
);

    logic [1:0]                                cnt_q;
    logic [(BYTES_PER_WORD-1)*BYTE_W-1:0]      pack_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt_q  <= '0;
            pack_q <= '0;
        end else if (clear) begin
            cnt_q  <= '0;
            pack_q <= '0;
        end else if (accept) begin
            cnt_q <= cnt_q + 2'd1;
            unique case (cnt_q)
                2'd0:    pack_q[7:0]   <= data;
                2'd1:    pack_q[15:8]  <= data;
                2'd2:    pack_q[23:16] <= data;
                default: ;
            endcase
        end
    end

    // The 4th byte bypasses the register so the word is available in the accepting cycle.
    assign word_valid = accept && (cnt_q == 2'd3);
    assign word       = {data, pack_q};

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams bytes into instruction memory, then raises cpu_enable.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing XOR checksum byte).
module imem_loader
    import loader_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = 64'h0,
    parameter int unsigned MAX_WORDS = 128,
    parameter int unsigned WCNT_W    = 8
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              load_start,
    input  logic [WCNT_W-1:0] word_count,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic [63:0]       addr_ext,
    output logic              wen_ext,
    output logic              ren_ext,
    output logic [31:0]       wdata_ext,
    output logic              cpu_enable,
    output logic              busy,
    output logic              error
);

    localparam logic [WCNT_W-1:0] OneW = WCNT_W'(1);

    loader_state_t     state_q;
    logic [WCNT_W-1:0] count_q;
    logic [WCNT_W-1:0] idx_q;
    logic [63:0]       addr_q;
    logic [31:0]       wdata_q;
    logic              start_ok;
    logic              in_recv;
    logic              word_valid;
    logic [31:0]       word;

    assign start_ok = load_start &&
                      (state_q == StIdle || state_q == StDone || state_q == StError);
    assign in_recv  = (state_q == StRecv);

    loader_byte_packer u_packer (
        .clk        (clk),
        .arst       (arst),
        .clear      (start_ok),
        .accept     (in_recv && s_valid),
        .data       (s_data),
        .word_valid (word_valid),
        .word       (word)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] xor_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            xor_q <= '0;
        end else if (start_ok) begin
            xor_q <= '0;
        end else if (in_recv && s_valid) begin
            xor_q <= xor_q ^ s_data;
        end
    end

    assign s_ready = in_recv || (state_q == StCheck);
`else
    assign s_ready = in_recv;
`endif

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= StIdle;
            count_q <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone, StError: begin
                    if (load_start) begin
                        if (word_count == '0) begin
                            state_q <= StDone;
                        end else if (32'(word_count) > MAX_WORDS) begin
                            state_q <= StError;
                        end else begin
                            count_q <= word_count;
                            idx_q   <= '0;
                            state_q <= StRecv;
                        end
                    end
                end
                StRecv: begin
                    // Address and data are captured here so they are stable during WRITE.
                    if (word_valid) begin
                        wdata_q <= word;
                        addr_q  <= BASE_ADDR + {{(62-WCNT_W){1'b0}}, idx_q, 2'b00};
                        state_q <= StWrite;
                    end
                end
                StWrite: begin
                    if (idx_q == count_q - OneW) begin
`ifdef LOADER_CHECKSUM_EN
                        state_q <= StCheck;
`else
                        state_q <= StDone;
`endif
                    end else begin
                        idx_q   <= idx_q + OneW;
                        state_q <= StRecv;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                StCheck: begin
                    if (s_valid) begin
                        state_q <= (s_data == xor_q) ? StDone : StError;
                    end
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

    assign wen_ext    = (state_q == StWrite);
    assign ren_ext    = 1'b0;
    assign addr_ext   = addr_q;
    assign wdata_ext  = wdata_q;
    assign cpu_enable = (state_q == StDone);
    assign error      = (state_q == StError);
    assign busy       = in_recv || wen_ext || (state_q == StCheck);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed corner sequences plus a
// table of randomized loads checked against a byte-level reference model.
module tb_imem_loader;

    localparam int unsigned   MAXW = 128;
    localparam logic [63:0]   BASE = 64'h0;

    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        int wc;
        int gap;
        int nw;
        bit exp_done;
        bit exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        load_start = 1'b0;
    logic [7:0]  word_count = '0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_ready;
    logic [63:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    logic        cpu_enable;
    logic        busy;
    logic        error;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] wr_addr[$];
    logic [31:0] wr_data[$];

    always #5 clk = ~clk;

    imem_loader #(
        .BASE_ADDR (BASE),
        .MAX_WORDS (MAXW),
        .WCNT_W    (8)
    ) dut (
        .clk        (clk),
        .arst       (arst),
        .load_start (load_start),
        .word_count (word_count),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .addr_ext   (addr_ext),
        .wen_ext    (wen_ext),
        .ren_ext    (ren_ext),
        .wdata_ext  (wdata_ext),
        .cpu_enable (cpu_enable),
        .busy       (busy),
        .error      (error)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Write monitor: records every memory write and checks the handshake exclusivity.
    always @(negedge clk) begin
        if (wen_ext === 1'b1) begin
            wr_addr.push_back(addr_ext);
            wr_data.push_back(wdata_ext);
            check("wen_with_ready", {63'b0, s_ready}, 64'h0);
        end
    end

    function automatic logic [31:0] word_of(input byte_q_t bq, input int i);
        return 32'(bq[4*i]) + 32'(bq[4*i+1]) * 32'd256 + 32'(bq[4*i+2]) * 32'd65536 +
               32'(bq[4*i+3]) * 32'd16777216;
    endfunction

    task automatic start_load(input int wc);
        @(negedge clk);
        load_start = 1'b1;
        word_count = wc[7:0];
        @(posedge clk);
        #1 load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard = 0;
        bit done  = 1'b0;
        if (gap == 1) begin
            @(negedge clk);
            s_valid = 1'b0;
        end else if (gap == 2) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                s_valid = 1'b0;
            end
        end
        while (!done && guard < 50) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = b;
            done    = s_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!done) timeout("byte_accept");
    endtask

    task automatic load_bytes(input int wc, input byte_q_t bq, input int gap);
        start_load(wc);
        foreach (bq[i]) send_byte(bq[i], gap);
        s_valid = 1'b0;
    endtask

    task automatic wait_end();
        int g = 0;
        while (!(cpu_enable || error) && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (!(cpu_enable || error)) timeout("load_end");
    endtask

    task automatic finish_load(input byte_q_t bq);
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] x = '0;
        foreach (bq[i]) x = x ^ bq[i];
        send_byte(x, 0);
        s_valid = 1'b0;
`endif
        wait_end();
    endtask

    task automatic check_writes(input byte_q_t bq, input int n);
        int m;
        check("wr_count", 64'(wr_addr.size()), 64'(n));
        m = (wr_addr.size() < n) ? wr_addr.size() : n;
        for (int i = 0; i < m; i++) begin
            check("wr_addr", wr_addr[i], BASE + 64'(4 * i));
            check("wr_data", 64'(wr_data[i]), 64'(word_of(bq, i)));
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t    vecs[8];
        byte_q_t bq;
        byte_q_t bq2;

        vecs[0] = '{wc: 0,   gap: 0, nw: 0,   exp_done: 1'b1, exp_err: 1'b0};
        vecs[1] = '{wc: 129, gap: 0, nw: 0,   exp_done: 1'b0, exp_err: 1'b1};
        vecs[2] = '{wc: 1,   gap: 0, nw: 1,   exp_done: 1'b1, exp_err: 1'b0};
        vecs[3] = '{wc: 3,   gap: 1, nw: 3,   exp_done: 1'b1, exp_err: 1'b0};
        vecs[4] = '{wc: 200, gap: 0, nw: 0,   exp_done: 1'b0, exp_err: 1'b1};
        vecs[5] = '{wc: 5,   gap: 2, nw: 5,   exp_done: 1'b1, exp_err: 1'b0};
        vecs[6] = '{wc: 128, gap: 0, nw: 128, exp_done: 1'b1, exp_err: 1'b0};
        vecs[7] = '{wc: 2,   gap: 2, nw: 2,   exp_done: 1'b1, exp_err: 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_cpu_enable", {63'b0, cpu_enable}, 64'h0);
        check("rst_busy", {63'b0, busy}, 64'h0);
        check("rst_error", {63'b0, error}, 64'h0);
        check("rst_s_ready", {63'b0, s_ready}, 64'h0);
        check("rst_wen", {63'b0, wen_ext}, 64'h0);
        check("rst_ren", {63'b0, ren_ext}, 64'h0);
        check("rst_addr", addr_ext, 64'h0);
        check("rst_wdata", 64'(wdata_ext), 64'h0);
        arst = 1'b0;

        // Two-word program with exact completion timing
        clear_log();
        bq = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        load_bytes(2, bq, 0);
        @(negedge clk);
        check("last_wen", {63'b0, wen_ext}, 64'h1);
        check("last_cpu_enable", {63'b0, cpu_enable}, 64'h0);
        @(negedge clk);
`ifdef LOADER_CHECKSUM_EN
        check("after_write_cpu_enable", {63'b0, cpu_enable}, 64'h0);
`else
        check("after_write_cpu_enable", {63'b0, cpu_enable}, 64'h1);
`endif
        finish_load(bq);
        check("prog_count", 64'(wr_addr.size()), 64'd2);
        if (wr_addr.size() == 2) begin
            check("prog_addr0", wr_addr[0], 64'h0);
            check("prog_data0", 64'(wr_data[0]), 64'h0000_0013);
            check("prog_addr1", wr_addr[1], 64'h4);
            check("prog_data1", 64'(wr_data[1]), 64'h0010_0093);
        end
        check("prog_done", {63'b0, cpu_enable}, 64'h1);

        // Reset in the middle of word 1, then a clean single-word reload
        bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        load_bytes(2, bq, 0);
        @(negedge clk);
        arst = 1'b1;
        #1;
        check("midrst_busy", {63'b0, busy}, 64'h0);
        check("midrst_wdata", 64'(wdata_ext), 64'h0);
        check("midrst_addr", addr_ext, 64'h0);
        check("midrst_s_ready", {63'b0, s_ready}, 64'h0);
        @(negedge clk);
        arst = 1'b0;
        clear_log();
        bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        load_bytes(1, bq, 0);
        finish_load(bq);
        check("reload_count", 64'(wr_addr.size()), 64'd1);
        if (wr_addr.size() == 1) check("reload_data", 64'(wr_data[0]), 64'hDDCC_BBAA);
        check("reload_error", {63'b0, error}, 64'h0);
        check("reload_done", {63'b0, cpu_enable}, 64'h1);

        // load_start while busy is ignored; load_start in DONE drops cpu_enable
        clear_log();
        bq = {};
        for (int i = 0; i < 8; i++) bq.push_back(8'($urandom));
        start_load(2);
        send_byte(bq[0], 0);
        send_byte(bq[1], 0);
        @(negedge clk);
        s_valid    = 1'b0;
        load_start = 1'b1;
        word_count = 8'd1;
        @(posedge clk);
        #1 load_start = 1'b0;
        check("ignored_start_busy", {63'b0, busy}, 64'h1);
        for (int i = 2; i < 8; i++) send_byte(bq[i], 0);
        s_valid = 1'b0;
        finish_load(bq);
        check_writes(bq, 2);
        check("ignored_start_done", {63'b0, cpu_enable}, 64'h1);
        start_load(1);
        @(negedge clk);
        check("restart_cpu_enable", {63'b0, cpu_enable}, 64'h0);
        check("restart_busy", {63'b0, busy}, 64'h1);
        clear_log();
        bq2 = {};
        for (int i = 0; i < 4; i++) bq2.push_back(8'($urandom));
        foreach (bq2[i]) send_byte(bq2[i], 0);
        s_valid = 1'b0;
        finish_load(bq2);
        check_writes(bq2, 1);

`ifdef LOADER_CHECKSUM_EN
        // Trailing checksum: correct XOR passes, wrong XOR errors
        bq = '{8'h01, 8'h02, 8'h04, 8'h08};
        load_bytes(1, bq, 0);
        send_byte(8'h0F, 0);
        s_valid = 1'b0;
        wait_end();
        check("ck_pass_done", {63'b0, cpu_enable}, 64'h1);
        load_bytes(1, bq, 0);
        send_byte(8'h0E, 0);
        s_valid = 1'b0;
        wait_end();
        check("ck_fail_error", {63'b0, error}, 64'h1);
        check("ck_fail_cpu_enable", {63'b0, cpu_enable}, 64'h0);
`endif

        // Randomized loads against the reference model
        for (int v = 0; v < 8; v++) begin
            clear_log();
            bq = {};
            for (int i = 0; i < 4 * vecs[v].nw; i++) bq.push_back(8'($urandom));
            load_bytes(vecs[v].wc, bq, vecs[v].gap);
            if (vecs[v].nw > 0) finish_load(bq);
            @(negedge clk);
            check("vec_cpu_enable", {63'b0, cpu_enable}, {63'b0, vecs[v].exp_done});
            check("vec_error", {63'b0, error}, {63'b0, vecs[v].exp_err});
            check("vec_busy", {63'b0, busy}, 64'h0);
            check_writes(bq, vecs[v].nw);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
